// File: rtl/fmt_db_pkg.sv
// Shared types and default widths for the double-buffered pin formatter.
// Format codes match the 2-bit per-channel FMT field from the pattern sequencer.
package fmt_db_pkg;

    localparam int DEF_CHANNELS = 8;
    localparam int DEF_EDGE_W   = 7;
    localparam int DEF_CYCLE_W  = 8;

    typedef enum logic [1:0] {
        FMT_NRZ = 2'b00,
        FMT_RZ  = 2'b01,
        FMT_R1  = 2'b10,
        FMT_SBC = 2'b11
    } fmt_t;

endpackage

// File: rtl/fmt_chan.sv
// One pin channel: shadow/active data+format registers and the registered edge/mode logic.
// Q settles on the edge that enters the matching tick; SBC complement only with FMT_DB_SBC_EN.
module fmt_chan
    import fmt_db_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic       copy_i,
    input  logic       run_i,
`ifdef FMT_DB_SBC_EN
    input  logic       start_i,
`endif
    input  logic       le_hit_i,
    input  logic       te_hit_i,
    input  logic       d_i,
    input  logic [1:0] fmt_i,
    output logic       q_o
);

    logic shadow_q, shadow_d;
    logic act_q, act_d;
    logic q_q, q_d;
    fmt_t sfmt_q, sfmt_d;
    fmt_t afmt_q, afmt_d;
    fmt_t mode;

    // A copy coinciding with a load takes the freshly loaded values.
    always_comb begin
        shadow_d = load_i ? d_i : shadow_q;
        sfmt_d   = load_i ? fmt_t'(fmt_i) : sfmt_q;
        act_d    = copy_i ? shadow_d : act_q;
        afmt_d   = copy_i ? sfmt_d : afmt_q;
    end

    always_comb begin
`ifdef FMT_DB_SBC_EN
        mode = afmt_d;
`else
        mode = (afmt_d == FMT_SBC) ? FMT_NRZ : afmt_d;
`endif
        q_d = q_q;
        if (run_i) begin
            if (le_hit_i) begin
                q_d = act_d;
            end else if (te_hit_i) begin
                case (mode)
                    FMT_RZ:  q_d = 1'b0;
                    FMT_R1:  q_d = 1'b1;
`ifdef FMT_DB_SBC_EN
                    FMT_SBC: q_d = ~act_d;
`endif
                    default: q_d = q_q;
                endcase
            end
`ifdef FMT_DB_SBC_EN
            else if (start_i && (mode == FMT_SBC)) begin
                q_d = ~act_d;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q <= 1'b0;
            sfmt_q   <= FMT_NRZ;
            act_q    <= 1'b0;
            afmt_q   <= FMT_NRZ;
            q_q      <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            sfmt_q   <= sfmt_d;
            act_q    <= act_d;
            afmt_q   <= afmt_d;
            q_q      <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fmt_db_bank.sv
// Multi-channel double-buffered pin formatter: tester-cycle counter, timing latch, transfer/overrun tracking.
// Q and CYCLE_START are registered together per tick; no backpressure. FMT_DB_SBC_EN enables SBC mode.
module fmt_db_bank
    import fmt_db_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int EDGE_W   = DEF_EDGE_W,
    parameter int CYCLE_W  = DEF_CYCLE_W
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  load_i,
    input  logic                  transfer_i,
    input  logic [CHANNELS-1:0]   d_i,
    input  logic [2*CHANNELS-1:0] fmt_i,
    input  logic                  test_cycle_i,
    input  logic [EDGE_W-1:0]     leading_edge_1_i,
    input  logic [EDGE_W-1:0]     trailing_edge_1_i,
    input  logic [EDGE_W-1:0]     leading_edge_2_i,
    input  logic [EDGE_W-1:0]     trailing_edge_2_i,
    input  logic [CYCLE_W-1:0]    cycle_length_1_i,
    input  logic [CYCLE_W-1:0]    cycle_length_2_i,
    input  logic                  clr_ovr_i,
    output logic [CHANNELS-1:0]   q_o,
    output logic                  cycle_start_o,
    output logic                  xfer_pending_o,
    output logic                  overrun_o
);

    localparam int CMP_W = ((EDGE_W > CYCLE_W) ? EDGE_W : CYCLE_W) + 1;

    logic rst_sync_q;
    logic rst_n;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rst_sync_q <= 1'b0;
        else          rst_sync_q <= 1'b1;
    end
    assign rst_n = rst_sync_q;

    logic [CYCLE_W-1:0] cnt_q, cnt_d, len_q, len_d;
    logic [EDGE_W-1:0]  le_q, le_d, te_q, te_d;
    logic               run_q, pend_q, pend_d, ovr_q, ovr_d, cs_q, cs_d;
    logic               last_tick, boundary, copy, le_hit, te_hit;

    // All *_d values describe the tick entered on the next edge, so Q lines up with cnt.
    always_comb begin
        last_tick = (len_q <= CYCLE_W'(1)) || (cnt_q == len_q - CYCLE_W'(1));
        cnt_d     = (en_i && run_q && !last_tick) ? cnt_q + CYCLE_W'(1) : '0;
        boundary  = (cnt_d == '0);

        len_d = len_q;
        le_d  = le_q;
        te_d  = te_q;
        if (boundary) begin
            len_d = test_cycle_i ? cycle_length_2_i  : cycle_length_1_i;
            le_d  = test_cycle_i ? leading_edge_2_i  : leading_edge_1_i;
            te_d  = test_cycle_i ? trailing_edge_2_i : trailing_edge_1_i;
        end

        le_hit = en_i && (CMP_W'(cnt_d) == CMP_W'(le_d)) && (CMP_W'(le_d) < CMP_W'(len_d));
        te_hit = en_i && (CMP_W'(cnt_d) == CMP_W'(te_d)) && (CMP_W'(te_d) < CMP_W'(len_d));

        copy   = boundary && (pend_q || transfer_i);
        pend_d = (pend_q || transfer_i) && !boundary;
        ovr_d  = (load_i && pend_q && !transfer_i) || (ovr_q && !clr_ovr_i);
        cs_d   = en_i && boundary;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            len_q  <= '0;
            le_q   <= '0;
            te_q   <= '0;
            run_q  <= 1'b0;
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
            cs_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            len_q  <= len_d;
            le_q   <= le_d;
            te_q   <= te_d;
            run_q  <= en_i;
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
            cs_q   <= cs_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        fmt_chan u_chan (
            .clk_i    (clk_i),
            .rst_ni   (rst_n),
            .load_i   (load_i),
            .copy_i   (copy),
            .run_i    (en_i),
`ifdef FMT_DB_SBC_EN
            .start_i  (boundary),
`endif
            .le_hit_i (le_hit),
            .te_hit_i (te_hit),
            .d_i      (d_i[c]),
            .fmt_i    (fmt_i[2*c +: 2]),
            .q_o      (q_o[c])
        );
    end

    assign cycle_start_o  = cs_q;
    assign xfer_pending_o = pend_q;
    assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_fmt_db_bank.sv
// Bench for fmt_db_bank: directed test-plan sequence plus randomized traffic against a tick-level model.
// Honours FMT_DB_SBC_EN the same way as the design build.
module tb_fmt_db_bank;

    logic        clk;
    logic        rst_n;
    logic        en, load, transfer, tc, clr;
    logic [7:0]  d;
    logic [15:0] fmt;
    logic [6:0]  le1, te1, le2, te2;
    logic [7:0]  len1, len2;
    logic [7:0]  q;
    logic        cs, xp, ovr;

    int n_tests = 0;
    int n_fail  = 0;
    int pos;
    logic [7:0] exp_q;

    // Reference model state: position inside the current tester cycle and per-channel buffers.
    int       m_pos, m_len, m_le, m_te;
    bit       m_run, m_pend, m_ovr, m_cs;
    bit [7:0] m_sh, m_act, m_q;
    int       m_sf[8];
    int       m_af[8];

    fmt_db_bank dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .en_i              (en),
        .load_i            (load),
        .transfer_i        (transfer),
        .d_i               (d),
        .fmt_i             (fmt),
        .test_cycle_i      (tc),
        .leading_edge_1_i  (le1),
        .trailing_edge_1_i (te1),
        .leading_edge_2_i  (le2),
        .trailing_edge_2_i (te2),
        .cycle_length_1_i  (len1),
        .cycle_length_2_i  (len2),
        .clr_ovr_i         (clr),
        .q_o               (q),
        .cycle_start_o     (cs),
        .xfer_pending_o    (xp),
        .overrun_o         (ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit next_level(int f, bit a, bit cur, int p, int le, int te, int len);
        int mode;
        mode = f;
`ifndef FMT_DB_SBC_EN
        if (mode == 3) mode = 0;
`endif
        if (p == le && le < len) return a;
        if (p == te && te < len) begin
            if (mode == 1) return 1'b0;
            if (mode == 2) return 1'b1;
            if (mode == 3) return !a;
        end
        if (mode == 3 && p == 0) return !a;
        return cur;
    endfunction

    task automatic model_reset();
        m_pos = 0; m_len = 0; m_le = 0; m_te = 0;
        m_run = 0; m_pend = 0; m_ovr = 0; m_cs = 0;
        m_sh = '0; m_act = '0; m_q = '0;
        for (int c = 0; c < 8; c++) begin
            m_sf[c] = 0;
            m_af[c] = 0;
        end
    endtask

    // Advance the model by one tick using the inputs currently driven.
    task automatic model_step();
        bit bnd;
        if (!en) begin
            m_pos = 0;
            m_run = 0;
        end else if (!m_run) begin
            m_pos = 0;
            m_run = 1;
        end else begin
            m_pos = (m_pos + 1) % ((m_len > 1) ? m_len : 1);
        end
        bnd = (m_pos == 0);
        if (bnd) begin
            m_len = tc ? int'(len2) : int'(len1);
            m_le  = tc ? int'(le2)  : int'(le1);
            m_te  = tc ? int'(te2)  : int'(te1);
        end
        if (load && m_pend && !transfer) m_ovr = 1;
        else if (clr)                    m_ovr = 0;
        if (load) begin
            m_sh = d;
            for (int c = 0; c < 8; c++) m_sf[c] = int'(fmt[2*c +: 2]);
        end
        if ((m_pend || transfer) && bnd) begin
            m_act  = m_sh;
            m_af   = m_sf;
            m_pend = 0;
        end else begin
            m_pend = m_pend || transfer;
        end
        m_cs = en && bnd;
        if (en) begin
            for (int c = 0; c < 8; c++)
                m_q[c] = next_level(m_af[c], m_act[c], m_q[c], m_pos, m_le, m_te, m_len);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_eq("q",   q,   m_q);
        check_eq("cs",  cs,  m_cs);
        check_eq("xp",  xp,  m_pend);
        check_eq("ovr", ovr, m_ovr);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_q"},   q,   8'h00);
        check_eq({tag, "_cs"},  cs,  1'b0);
        check_eq({tag, "_xp"},  xp,  1'b0);
        check_eq({tag, "_ovr"}, ovr, 1'b0);
    endtask

    task automatic rand_run(input int n);
        for (int i = 0; i < n; i++) begin
            en       = ($urandom_range(0, 24) != 0);
            load     = ($urandom_range(0, 5) == 0);
            transfer = ($urandom_range(0, 7) == 0);
            clr      = ($urandom_range(0, 9) == 0);
            d        = 8'($urandom);
            fmt      = 16'($urandom);
            if ($urandom_range(0, 29) == 0) tc = ~tc;
            if ($urandom_range(0, 39) == 0) begin
                len1 = 8'($urandom_range(0, 12));
                len2 = 8'($urandom_range(0, 12));
                le1  = 7'($urandom_range(0, 13));
                te1  = 7'($urandom_range(0, 13));
                le2  = 7'($urandom_range(0, 13));
                te2  = 7'($urandom_range(0, 13));
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 0; load = 0; transfer = 0; tc = 0; clr = 0;
        d = '0; fmt = '0; le1 = '0; te1 = '0; le2 = '0; te2 = '0; len1 = '0; len2 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst");
        rst_n = 1'b1;
        en = 1'b1;
        @(posedge clk);
        #1;
        check_zero("rst_release");

        // Load + transfer with EN low: copy is immediate, pending never shows, Q holds.
        en = 0; len1 = 8'd10; le1 = 7'd2; te1 = 7'd6;
        len2 = 8'd6; le2 = 7'd1; te2 = 7'd4;
        fmt = 16'h5555; d = 8'hFF; load = 1; transfer = 1;
        tick();
        check_eq("pre_xp", xp, 1'b0);
        check_eq("pre_q",  q,  8'h00);

        // RZ pulse at cnt 2..5, mid-cycle transfer, then overrun set/clear/set-wins.
        for (int k = 0; k < 50; k++) begin
            pos = k % 10;
            en = 1; load = 0; transfer = 0; clr = 0;
            if (k == 14) begin d = 8'h0F; load = 1; transfer = 1; end
            if (k == 41) begin d = 8'hA5; load = 1; transfer = 1; end
            if (k == 42) begin d = 8'h3C; load = 1; end
            if (k == 43) clr = 1;
            if (k == 44) begin load = 1; clr = 1; end
            tick();
            exp_q = (pos >= 2 && pos <= 5) ? ((k >= 20) ? 8'h0F : 8'hFF) : 8'h00;
            check_eq("dir_q",   q,   exp_q);
            check_eq("dir_cs",  cs,  pos == 0);
            check_eq("dir_xp",  xp,  (k >= 14 && k <= 19) || (k >= 41 && k <= 49));
            check_eq("dir_ovr", ovr, (k == 42) || (k >= 44));
        end

        load = 0; transfer = 0; clr = 0;
        rand_run(3000);

        // Asynchronous reset mid-cycle, then synchronised release.
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("arst");
        model_reset();
        @(posedge clk);
        #1;
        check_zero("arst_hold");
        #2;
        rst_n = 1'b1;
        en = 1'b1;
        @(posedge clk);
        #1;
        check_zero("arst_release");

        rand_run(1500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
